alu_operand_fetch: RTL and testbench

//   Operand-fetch stage directly upstream of the ALU. Holds the 32-entry register file and

---
 rtl/alu_operand_fetch.sv | 94 +++++++++
 tb/tb_alu_operand_fetch.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage ahead of the ALU: 32-entry register file, one issue per cycle,
// registered operand/control slot with valid/ready handshake and write-back bypass.
module alu_operand_fetch #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   output logic              issue_ready,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   input  logic [3:0]        alu_ctrl_in,
   input  logic [2:0]        bonus_ctrl_in,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              op_valid,
   input  logic              alu_ready,
   output logic [DATA_W-1:0] src1,
   output logic [DATA_W-1:0] src2,
   output logic [3:0]        ALU_control,
   output logic [2:0]        bonus_control
);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} slot_e;

   slot_e             state_q;
   logic [DATA_W-1:0] rf_q [NUM_REGS];
   logic [DATA_W-1:0] src1_q, src2_q;
   logic [3:0]        ctrl_q;
   logic [2:0]        bonus_q;
   logic [ADDR_W-1:0] rs_q, rt_q;

   logic              accept_c;
   logic              wb_we_c;
   logic [DATA_W-1:0] rd1_c, rd2_c;

   assign op_valid      = (state_q == S_FULL);
   assign issue_ready   = (state_q == S_EMPTY) || alu_ready;
   assign accept_c      = issue_valid && issue_ready;
   assign wb_we_c       = wb_en && (wb_addr != '0) && (32'(wb_addr) < NUM_REGS);
   assign src1          = src1_q;
   assign src2          = src2_q;
   assign ALU_control   = ctrl_q;
   assign bonus_control = bonus_q;

   // Register read with r0 forced to zero and same-cycle write-back bypass
   always_comb begin
      rd1_c = '0;
      rd2_c = '0;
      if (rs_addr != '0) begin
         if (wb_en && (wb_addr == rs_addr)) rd1_c = wb_data;
         else                               rd1_c = rf_q[rs_addr];
      end
      if (rt_addr != '0) begin
         if (wb_en && (wb_addr == rt_addr)) rd2_c = wb_data;
         else                               rd2_c = rf_q[rt_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_EMPTY;
         src1_q  <= '0;
         src2_q  <= '0;
         ctrl_q  <= '0;
         bonus_q <= '0;
         rs_q    <= '0;
         rt_q    <= '0;
         for (int i = 0; i < int'(NUM_REGS); i++) rf_q[i] <= '0;
      end else begin
         if (wb_we_c) rf_q[wb_addr] <= wb_data;

         if (accept_c) begin
            state_q <= S_FULL;
            src1_q  <= rd1_c;
            src2_q  <= rd2_c;
            ctrl_q  <= alu_ctrl_in;
            bonus_q <= bonus_ctrl_in;
            rs_q    <= rs_addr;
            rt_q    <= rt_addr;
         end else if (state_q == S_FULL && alu_ready) begin
            state_q <= S_EMPTY;
         end else if (state_q == S_FULL) begin
            // Stalled op keeps its operands current with write-back traffic
            if (wb_we_c && (wb_addr == rs_q)) src1_q <= wb_data;
            if (wb_we_c && (wb_addr == rt_q)) src2_q <= wb_data;
         end
      end
   end

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch: reference model of the register file and
// output slot checked every cycle, plus hand-computed literal expectations.
module tb_alu_operand_fetch;

   logic        clk = 1'b0;
   logic        rst_n, issue_valid, wb_en, alu_ready;
   logic [4:0]  rs_addr, rt_addr, wb_addr;
   logic [3:0]  alu_ctrl_in;
   logic [2:0]  bonus_ctrl_in;
   logic [31:0] wb_data;
   logic        issue_ready, op_valid;
   logic [31:0] src1, src2;
   logic [3:0]  ALU_control;
   logic [2:0]  bonus_control;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // reference model state
   bit [31:0] m_rf [32];
   bit        m_valid;
   bit [31:0] m_src1, m_src2;
   bit [3:0]  m_ctrl;
   bit [2:0]  m_bonus;
   bit [4:0]  m_rs, m_rt;

   always #5 clk = ~clk;

   alu_operand_fetch dut (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .alu_ctrl_in(alu_ctrl_in),
      .bonus_ctrl_in(bonus_ctrl_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .op_valid(op_valid), .alu_ready(alu_ready), .src1(src1), .src2(src2),
      .ALU_control(ALU_control), .bonus_control(bonus_control)
   );

   function automatic bit [31:0] m_read(input bit [4:0] a);
      if (a == 0) return 32'h0;
      if (wb_en && wb_addr == a) return wb_data;
      return m_rf[a];
   endfunction

   // Advance the model by one rising edge using the inputs currently applied
   task automatic m_update();
      bit rdy;
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
         m_valid = 0; m_src1 = 0; m_src2 = 0; m_ctrl = 0; m_bonus = 0; m_rs = 0; m_rt = 0;
         return;
      end
      rdy = !m_valid || alu_ready;
      if (issue_valid && rdy) begin
         m_src1 = m_read(rs_addr); m_src2 = m_read(rt_addr);
         m_ctrl = alu_ctrl_in; m_bonus = bonus_ctrl_in;
         m_rs = rs_addr; m_rt = rt_addr; m_valid = 1;
      end else if (m_valid && !alu_ready) begin
         if (wb_en && wb_addr != 0 && wb_addr == m_rs) m_src1 = wb_data;
         if (wb_en && wb_addr != 0 && wb_addr == m_rt) m_src2 = wb_data;
      end else begin
         m_valid = 0;
      end
      if (wb_en && wb_addr != 0) m_rf[wb_addr] = wb_data;
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("op_valid", 32'(op_valid), 32'(m_valid));
         cmp("issue_ready", 32'(issue_ready), 32'(!m_valid || alu_ready));
         if (m_valid) begin
            cmp("src1", src1, m_src1);
            cmp("src2", src2, m_src2);
            cmp("ALU_control", 32'(ALU_control), 32'(m_ctrl));
            cmp("bonus_control", 32'(bonus_control), 32'(m_bonus));
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
      m_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 0; wb_en = 0; alu_ready = 1;
   endtask

   task automatic issue(input bit [4:0] rs, input bit [4:0] rt, input bit [3:0] c, input bit [2:0] b);
      issue_valid = 1; rs_addr = rs; rt_addr = rt; alu_ctrl_in = c; bonus_ctrl_in = b;
   endtask

   task automatic wb(input bit [4:0] a, input bit [31:0] d);
      wb_en = 1; wb_addr = a; wb_data = d;
   endtask

   initial begin
      rst_n = 0; idle();
      rs_addr = 0; rt_addr = 0; alu_ctrl_in = 0; bonus_ctrl_in = 0; wb_addr = 0; wb_data = 0;
      tick(); tick();
      chk_en = 1;
      rst_n = 1;
      cmp("reset op_valid", 32'(op_valid), 32'h0);
      cmp("reset src1", src1, 32'h0);
      cmp("reset ALU_control", 32'(ALU_control), 32'h0);

      // read of never-written registers
      issue(3, 7, 4'd1, 3'd0); tick(); idle();
      cmp("lit r3r7 op_valid", 32'(op_valid), 32'h1);
      cmp("lit r3 src1", src1, 32'h0);
      cmp("lit r7 src2", src2, 32'h0);

      // write then read
      wb(5, 32'h0000_0010); tick(); idle();
      issue(5, 0, 4'd2, 3'd3); tick(); idle();
      cmp("lit r5 src1", src1, 32'h10);
      cmp("lit r0 src2", src2, 32'h0);
      cmp("lit ctrl 2", 32'(ALU_control), 32'h2);
      cmp("lit bonus 3", 32'(bonus_control), 32'h3);

      // same-cycle write-back bypass
      wb(9, 32'hDEAD_BEEF); issue(9, 9, 4'd4, 3'd1); tick(); idle();
      cmp("lit bypass src1", src1, 32'hDEAD_BEEF);
      cmp("lit bypass src2", src2, 32'hDEAD_BEEF);

      // r0 write ignored
      wb(0, 32'hFFFF_FFFF); tick(); idle();
      issue(0, 0, 4'd5, 3'd2); tick(); idle();
      cmp("lit r0 read", src1, 32'h0);

      // stall with held-operand refresh
      wb(4, 32'h0000_0055); tick(); idle();
      issue(4, 6, 4'd7, 3'd5); tick();
      cmp("lit r4 before stall", src1, 32'h55);
      alu_ready = 0; issue(5, 9, 4'd3, 3'd6); tick();
      cmp("lit stall issue_ready", 32'(issue_ready), 32'h0);
      cmp("lit stall ctrl", 32'(ALU_control), 32'h7);
      wb(4, 32'h0000_1234); tick(); wb_en = 0;
      cmp("lit refresh src1", src1, 32'h1234);
      cmp("lit refresh bonus", 32'(bonus_control), 32'h5);
      tick();
      cmp("lit stall3 src1", src1, 32'h1234);
      alu_ready = 1; tick(); idle();
      cmp("lit next op src1", src1, 32'h10);
      cmp("lit next op src2", src2, 32'hDEAD_BEEF);
      cmp("lit next op ctrl", 32'(ALU_control), 32'h3);

      // back-to-back issues with ready toggling
      for (int i = 1; i < 12; i++) begin
         issue(5'(i), 5'(i + 3), 4'(i), 3'(i));
         alu_ready = (i % 3) != 0;
         if (i % 2 == 0) wb(5'(i + 3), 32'h100 * 32'(i));
         else wb_en = 0;
         tick();
      end
      idle();

      // reset during a stall
      issue(5, 9, 4'd9, 3'd4); tick();
      issue_valid = 0; alu_ready = 0; tick();
      rst_n = 0; tick();
      cmp("lit rst stall op_valid", 32'(op_valid), 32'h0);
      cmp("lit rst stall src1", src1, 32'h0);
      cmp("lit rst stall ctrl", 32'(ALU_control), 32'h0);
      rst_n = 1; idle();
      issue(5, 9, 4'd1, 3'd1); tick(); idle();
      cmp("lit r5 after reset", src1, 32'h0);
      cmp("lit r9 after reset", src2, 32'h0);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
